dnn_out_stage: RTL
==================

DNN_OUT_STAGE -- requirements
Module: dnn_out_stage

Interface
REQ-001 Parameter HW, default 21, hidden-activation width (signed).
REQ-002 Parameter WW, default 6, weight width (signed).
REQ-003 Parameter AW, default 29, accumulator/output width (signed); AW >= HW+WW+2.
REQ-004 clk  input  1  single clock; all state updates on posedge clk.
REQ-005 rst_n  input  1  reset; asynchronous, active-low.
REQ-006 h0,h1,h2,h3  input  HW each  signed hidden activations from stage 1.
REQ-007 w48,w58,w68,w78  input  WW each  signed weights feeding output 8.
REQ-008 w49,w59,w69,w79  input  WW each  signed weights feeding output 9.
REQ-009 stg_2_rdy  input  1  stage-1 valid; h*/w* valid while high.
REQ-010 in_rdy  output  1  block can accept a new input set.
REQ-011 y8,y9  output  AW each  signed output-layer sums, registered.
REQ-012 cls  output  1  argmax: 1 when y9 > y8, else 0.
REQ-013 out_vld  output  1  y8/y9/cls valid.
REQ-014 out_rdy  input  1  downstream accepts the result.

Function
REQ-015 FSM states IDLE, MAC, DONE; in_rdy = 1 only in IDLE (combinational from state).
REQ-016 IDLE: on stg_2_rdy=1 at posedge, capture h0-h3 and all eight weights into internal registers, clear both accumulators, clear idx, go to MAC.
REQ-017 MAC: each cycle acc8 += hreg[idx]*w8reg[idx] and acc9 += hreg[idx]*w9reg[idx]; idx increments 0..3 (2-bit counter).
REQ-018 MAC: when idx=3 at the edge, the final products are added, y8/y9/cls load from the final sums, out_vld sets, go to DONE.
REQ-019 Latency: out_vld rises exactly 4 clock edges after the capture edge; throughput one result per 5+ cycles.
REQ-020 Products HW+WW bits, sign-extended to AW before accumulation; arithmetic exact, no saturation, no ReLU.
REQ-021 cls computed from the full AW-bit signed final sums; tie (y8 = y9) gives cls=0.
REQ-022 DONE: outputs held stable while out_vld=1 and out_rdy=0.
REQ-023 DONE with out_rdy=1: out_vld clears, go to IDLE; y8/y9/cls retain last values.
REQ-024 stg_2_rdy while in MAC or DONE is ignored; no capture, no state change; upstream holds data until in_rdy.
REQ-025 Input changes after the capture edge have no effect on the result in progress.
REQ-026 out_rdy while out_vld=0 is ignored.

Reset
REQ-027 rst_n=0 asynchronously forces state=IDLE, idx=0, acc8=acc9=0, y8=y9=0, cls=0, out_vld=0, all capture registers 0.
REQ-028 Reset asserted during MAC or DONE discards the computation; no out_vld pulse follows release.
REQ-029 First capture possible on the first posedge after rst_n deasserts.

Structure
REQ-030 Shared package dnn_pkg holds HW/WW/AW defaults, the state enum (IDLE, MAC, DONE) and the signed activation/weight/accumulator typedefs.
REQ-031 One sub-module dnn_mac (signed multiply, sign-extend, accumulate, sync clear, async reset), instantiated twice for outputs 8 and 9.

Verification
REQ-032 h=(1,2,3,4), w8=(1,1,1,1), w9=(2,0,0,0), out_rdy=1 -> 4 edges after capture y8=10, y9=2, cls=0, out_vld for one cycle.
REQ-033 h=(-5,0,0,7), w8=(-32,0,0,31), w9=(31,0,0,-32) -> y8=377, y9=-379, cls=0; repeat with w8/w9 swapped -> cls=1.
REQ-034 Max magnitude: h all =-1048576, all weights =-32 -> y8=y9=134217728, cls=0 (tie), no overflow.
REQ-035 out_rdy=0 for 10 cycles after out_vld -> y8/y9/cls/out_vld stable, in_rdy=0, a new stg_2_rdy ignored; out_rdy=1 -> IDLE next edge, then new capture accepted.
REQ-036 rst_n pulsed low at MAC idx=2 -> all outputs 0 immediately, state IDLE, no out_vld after release; next transaction correct.

Source files
------------

// File: rtl/dnn_pkg.sv
// Shared definitions for the DNN output stage: default widths, control
// state encoding and signed datapath types.
package dnn_pkg;

  localparam int HW_DEF = 21;  // hidden-activation width
  localparam int WW_DEF = 6;   // weight width
  localparam int AW_DEF = 29;  // accumulator / output width
  localparam int N_TAPS = 4;   // hidden units feeding each output

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef logic signed [HW_DEF-1:0] act_t;
  typedef logic signed [WW_DEF-1:0] wgt_t;
  typedef logic signed [AW_DEF-1:0] acc_t;

endpackage

// File: rtl/dnn_mac.sv
// Signed multiply-accumulate lane: one product per enabled cycle, exact
// arithmetic, synchronous clear. sum is the value acc takes on the next edge.
module dnn_mac
  import dnn_pkg::*;
#(
  parameter int HW = HW_DEF,
  parameter int WW = WW_DEF,
  parameter int AW = AW_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 en,
  input  logic signed [HW-1:0] h,
  input  logic signed [WW-1:0] w,
  output logic signed [AW-1:0] sum
);

  localparam int PW = HW + WW;

  logic signed [PW-1:0] prod;
  logic signed [AW-1:0] prod_ext;
  logic signed [AW-1:0] acc;

  // Size casts of signed operands sign-extend, so the product is exact in PW bits.
  assign prod     = PW'(h) * PW'(w);
  assign prod_ext = AW'(prod);
  assign sum      = acc + prod_ext;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= sum;
    end
  end

endmodule

// File: rtl/dnn_out_stage.sv
// Output layer of a small DNN: captures four activations and two weight sets,
// accumulates both dot products over four cycles, then presents y8/y9 and argmax.
module dnn_out_stage
  import dnn_pkg::*;
#(
  parameter int HW = HW_DEF,
  parameter int WW = WW_DEF,
  parameter int AW = AW_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic signed [HW-1:0] h0,
  input  logic signed [HW-1:0] h1,
  input  logic signed [HW-1:0] h2,
  input  logic signed [HW-1:0] h3,
  input  logic signed [WW-1:0] w48,
  input  logic signed [WW-1:0] w58,
  input  logic signed [WW-1:0] w68,
  input  logic signed [WW-1:0] w78,
  input  logic signed [WW-1:0] w49,
  input  logic signed [WW-1:0] w59,
  input  logic signed [WW-1:0] w69,
  input  logic signed [WW-1:0] w79,
  input  logic                 stg_2_rdy,
  output logic                 in_rdy,
  output logic signed [AW-1:0] y8,
  output logic signed [AW-1:0] y9,
  output logic                 cls,
  output logic                 out_vld,
  input  logic                 out_rdy
);

  state_t               state;
  logic [1:0]           idx;
  logic signed [HW-1:0] h_reg  [N_TAPS];
  logic signed [WW-1:0] w8_reg [N_TAPS];
  logic signed [WW-1:0] w9_reg [N_TAPS];

  logic                 capture;
  logic                 mac_en;
  logic signed [AW-1:0] sum8;
  logic signed [AW-1:0] sum9;

  assign in_rdy  = (state == IDLE);
  assign capture = in_rdy && stg_2_rdy;
  assign mac_en  = (state == MAC);

  dnn_mac #(.HW(HW), .WW(WW), .AW(AW)) u_mac8 (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (capture),
    .en    (mac_en),
    .h     (h_reg[idx]),
    .w     (w8_reg[idx]),
    .sum   (sum8)
  );

  dnn_mac #(.HW(HW), .WW(WW), .AW(AW)) u_mac9 (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (capture),
    .en    (mac_en),
    .h     (h_reg[idx]),
    .w     (w9_reg[idx]),
    .sum   (sum9)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      idx     <= '0;
      y8      <= '0;
      y9      <= '0;
      cls     <= 1'b0;
      out_vld <= 1'b0;
      // NOTE: the capture registers are small and must read as zero after
      // reset, so they are reset explicitly rather than left as bare storage.
      for (int i = 0; i < N_TAPS; i++) begin
        h_reg[i]  <= '0;
        w8_reg[i] <= '0;
        w9_reg[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (stg_2_rdy) begin
            h_reg[0]  <= h0;
            h_reg[1]  <= h1;
            h_reg[2]  <= h2;
            h_reg[3]  <= h3;
            w8_reg[0] <= w48;
            w8_reg[1] <= w58;
            w8_reg[2] <= w68;
            w8_reg[3] <= w78;
            w9_reg[0] <= w49;
            w9_reg[1] <= w59;
            w9_reg[2] <= w69;
            w9_reg[3] <= w79;
            idx       <= '0;
            state     <= MAC;
          end
        end
        MAC: begin
          idx <= idx + 2'd1;
          // Last tap: results load from the sums that include the final product.
          if (idx == 2'd3) begin
            y8      <= sum8;
            y9      <= sum9;
            cls     <= (sum9 > sum8);
            out_vld <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          if (out_rdy) begin
            out_vld <= 1'b0;
            state   <= IDLE;
          end
        end
        default: begin
          out_vld <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule
